// File: rtl/mac512_pkg.sv
// Shared constants and types for the 512-bit MAC result unloader.
package mac512_pkg;

  localparam int MAC_PROD_W    = 512;
  localparam int MAC_WORD_W    = 32;
  localparam int MAC_NUM_WORDS = MAC_PROD_W / MAC_WORD_W;
  localparam int MAC_IDX_W     = 5;

  typedef logic [MAC_IDX_W-1:0] idx_t;

  // CKSUM is always declared so the encoding does not depend on the build.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CKSUM = 2'd2
  } state_t;

endpackage

// File: rtl/mac512_result_unloader_if.sv
// Product-capture and word-stream signals of the MAC result unloader.
interface mac512_result_unloader_if #(
  parameter int PROD_W = mac512_pkg::MAC_PROD_W,
  parameter int WORD_W = mac512_pkg::MAC_WORD_W
);
  // Handshakes: a product is captured on a cycle with prod_vld & prod_rdy, and a word
  // moves on a cycle with m_valid & m_ready; m_data/m_idx/m_last hold while stalled.
  logic [PROD_W-1:0]      prod_in;
  logic                   prod_vld;
  logic                   prod_rdy;
  logic [WORD_W-1:0]      m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;
  mac512_pkg::idx_t       m_idx;
  logic                   ovf_err;
  logic                   clr_err;

  // master: the unloader (drives the word stream); slave: MAC plus downstream sink.
  modport master (
    input  prod_in, prod_vld, m_ready, clr_err,
    output prod_rdy, m_data, m_valid, m_last, m_idx, ovf_err
  );

  modport slave (
    output prod_in, prod_vld, m_ready, clr_err,
    input  prod_rdy, m_data, m_valid, m_last, m_idx, ovf_err
  );

endinterface

// File: rtl/mac512_result_unloader.sv
// Captures a 512-bit MAC product and streams it out LSW first as 32-bit words.
// Define MAC_UNLOAD_CKSUM_EN to append an XOR checksum word after the data words.
module mac512_result_unloader
  import mac512_pkg::*;
#(
  parameter int PROD_W = MAC_PROD_W,
  parameter int WORD_W = MAC_WORD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  mac512_result_unloader_if.master    bus,
  output state_t                      dbg_state
);

  localparam int   NUM_WORDS = PROD_W / WORD_W;
  localparam int   SEL_W     = $clog2(NUM_WORDS);
  localparam idx_t LAST_IDX  = idx_t'(NUM_WORDS - 1);
`ifndef MAC_UNLOAD_CKSUM_EN
  localparam idx_t PENULT_IDX = idx_t'(NUM_WORDS - 2);
`endif

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   hold_q, hold_d;
  idx_t                idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                ovf_q, ovf_d;
`ifdef MAC_UNLOAD_CKSUM_EN
  logic [WORD_W-1:0]   cksum_q, cksum_d;
`endif

  logic                xfer;
  logic                ovf_set;
  logic [WORD_W-1:0]   cur_word;
  logic [WORD_W-1:0]   out_word;

  assign xfer     = valid_q & bus.m_ready;
  assign ovf_set  = bus.prod_vld & (state_q != IDLE);
  assign cur_word = hold_q[idx_q[SEL_W-1:0]*WORD_W +: WORD_W];

`ifdef MAC_UNLOAD_CKSUM_EN
  assign out_word = (state_q == CKSUM) ? cksum_q : cur_word;
`else
  assign out_word = cur_word;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef MAC_UNLOAD_CKSUM_EN
    cksum_d = cksum_q;
`endif
    // A new overflow outranks a simultaneous clear.
    ovf_d   = (ovf_q & ~bus.clr_err) | ovf_set;

    case (state_q)
      IDLE: begin
        if (bus.prod_vld) begin
          state_d = SEND;
          hold_d  = bus.prod_in;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = 1'b0;
`ifdef MAC_UNLOAD_CKSUM_EN
          cksum_d = '0;
`endif
        end
      end
      SEND: begin
        if (xfer) begin
`ifdef MAC_UNLOAD_CKSUM_EN
          cksum_d = cksum_q ^ cur_word;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef MAC_UNLOAD_CKSUM_EN
            state_d = CKSUM;
            idx_d   = idx_q + idx_t'(1);
            last_d  = 1'b1;
`else
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
`endif
          end else begin
            idx_d = idx_q + idx_t'(1);
`ifdef MAC_UNLOAD_CKSUM_EN
            last_d = 1'b0;
`else
            last_d = (idx_q == PENULT_IDX);
`endif
          end
        end
      end
      CKSUM: begin
        if (xfer) begin
          state_d = IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef MAC_UNLOAD_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
`ifdef MAC_UNLOAD_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  assign bus.prod_rdy = (state_q == IDLE);
  assign bus.m_valid  = valid_q;
  assign bus.m_data   = valid_q ? out_word : '0;
  assign bus.m_idx    = idx_q;
  assign bus.m_last   = last_q;
  assign bus.ovf_err  = ovf_q;
  assign dbg_state    = state_q;

endmodule
